cnn_load_ctrl: RTL
==================

# cnn_load_ctrl

Load-side front end inside the CNN accelerator. It accepts 256-bit weight and ifmap lines from the COP agent's load FIFO over two valid/ready channels. A round-robin arbiter picks one line at a time. The line is serialised into four 64-bit beats and written into the weight SRAM or the ifmap SRAM. Per-channel line counters are kept for status.

## Interface
Parameters:
- SRAM_AW, 12: line address width carried on loadw/loadi.
- LINE_W, 256: line width.
- BEAT_W, 64: SRAM word width. LINE_W/BEAT_W = 4 beats per line, fixed.
- CNT_W, 16: line counter width.

Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  reset, synchronous and active-high.
- loadw_vld  in  1  weight line valid.
- loadw_addr  in  SRAM_AW  weight line address.
- loadw_data  in  LINE_W  weight line data.
- loadw_rdy  out  1  weight line accepted when high together with loadw_vld.
- loadi_vld / loadi_addr / loadi_data / loadi_rdy: the same four signals for ifmap lines.
- lock  in  1  accelerator busy; no new line is accepted while high.
- clr_cnt  in  1  clears both line counters.
- wsram_we  out  1  weight SRAM write enable.
- wsram_addr  out  SRAM_AW+2  weight SRAM word address.
- wsram_wdata  out  BEAT_W  weight SRAM write data.
- isram_we / isram_addr / isram_wdata: the same three signals for the ifmap SRAM.
- idle  out  1  high when no line is in flight.
- wline_cnt  out  CNT_W  weight lines accepted (saturating).
- iline_cnt  out  CNT_W  ifmap lines accepted (saturating).

## Operation
- FSM states: IDLE and WRITE. Registers:
  - line_buf: LINE_W bits.
  - line_addr: SRAM_AW bits.
  - tgt: 0 = weight, 1 = ifmap.
  - beat: 2 bits.
  - last_grant: 0 = weight, 1 = ifmap.
- Accept window: state==IDLE, or state==WRITE with beat==3; and lock==0.
- Grant rules inside the accept window:
  - Only one vld high: that channel is granted.
  - Both vld high: the channel opposite last_grant is granted.
- rdy is high only for the granted channel, only inside the accept window.
- Handshake: a line is accepted on a clock edge where vld&&rdy.
  - Source vld must not depend on rdy.
  - vld/addr/data must stay stable until accepted.
- On accept:
  - line_buf, line_addr and tgt load from the granted channel.
  - beat is set to 0, last_grant is set to tgt, state goes to WRITE.
- In WRITE, the target SRAM's we=1, addr={line_addr, beat}, wdata=line_buf[beat*64 +: 64].
  - Beat 0 carries bits [63:0].
  - beat increments every cycle.
  - After beat 3 with no accept, state goes to IDLE.
  - After beat 3 with an accept, the next line starts at beat 0 with no gap.
- The non-target SRAM has we=0. Address and data of an idle port hold their last values.
- lock does not abort the line in progress; it only blocks new accepts.
- Counters:
  - The counter of the accepted channel increments on accept and saturates at 2^CNT_W-1.
  - clr_cnt zeroes both counters.
  - clr_cnt coincident with an accept leaves the accepted channel's counter at 1.
- idle = (state==IDLE).
- Reset mid-line: the line is abandoned. No further we pulses. The line is not counted again.

## Timing
- Reset values (all outputs):
  - wsram_we=0, isram_we=0.
  - wsram_addr=0, isram_addr=0.
  - wsram_wdata=0, isram_wdata=0.
  - wline_cnt=0, iline_cnt=0.
  - loadw_rdy=0 and loadi_rdy=0 while rst is high.
  - idle=1.
- Internal reset state: state=IDLE, last_grant=1, so weight wins the first tie.
- SRAM-side outputs are registered or decoded from registers only. No combinational path from load inputs.
- rdy is combinational from state, beat, lock and both vld.
- Latency: accept at edge T gives we high in cycles T+1..T+4.
- Sustained throughput is one line per 4 cycles.
- The first line after IDLE costs one extra cycle.
- rst takes effect on the next rising edge. we is low in the cycle after that edge.

## Structure
- Shared package cnn_pkg holds:
  - the FSM state enum (LD_IDLE, LD_WRITE);
  - localparams BEATS_PER_LINE=4 and BEAT_IDX_W=2;
  - the tgt encoding (TGT_W=0, TGT_I=1).
- One sub-module, cnn_rr_arb2: a 2-requester round-robin arbiter.
  - Inputs: req[1:0], en, last.
  - Output: one-hot grant.
- The arbiter is purely combinational. last_grant is held in cnn_load_ctrl.

## Test plan
- Single loadw, addr=0x005, data words {D,C,B,A}:
  - wsram_we high cycles T+1..T+4.
  - wsram_addr 0x014..0x017; wdata A,B,C,D.
  - wline_cnt=1; isram_we never high.
- loadw_vld and loadi_vld both held high from reset, 4 lines each:
  - grants alternate W,I,W,I,...
  - we asserted 32 consecutive cycles with no gap after the first accept.
- lock raised during beat 1 of a loadi line:
  - the line finishes all 4 beats.
  - both rdy stay 0 until lock falls.
  - then the next line is accepted in the first unlocked accept-window cycle.
- wline_cnt preloaded to 0xFFFF by 65535 accepts, one more accept:
  - wline_cnt stays 0xFFFF.
- clr_cnt pulsed on the same edge as a loadi accept:
  - iline_cnt=1, wline_cnt=0.
- rst asserted during beat 2:
  - we=0 from the next cycle; idle=1; counters=0.
  - remaining beats never written.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types and constants for the CNN load-side front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // Load controller state
    typedef enum logic [0:0] {
        LD_IDLE  = 1'b0,
        LD_WRITE = 1'b1
    } ld_state_t;

    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_IDX_W     = 2;

    // Target SRAM encoding, also used as the grant bit index
    localparam logic TGT_W = 1'b0;
    localparam logic TGT_I = 1'b1;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/cnn_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_rr_arb2
//  Description : Two-requester round-robin arbiter, purely combinational.
//                grant[0] = weight channel, grant[1] = ifmap channel.
//                On a tie the requester opposite 'last' wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_rr_arb2
    import cnn_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; nothing granted outside the enable window
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = (last == TGT_I) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule : cnn_rr_arb2
`default_nettype wire

// File: rtl/cnn_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_load_ctrl
//  Description : Accepts 256-bit weight / ifmap lines over two valid/ready
//                channels, arbitrates round-robin, serialises each line into
//                four 64-bit beats written to the weight or ifmap SRAM, and
//                keeps saturating per-channel line counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_load_ctrl
    import cnn_pkg::*;
#(
    parameter int SRAM_AW = 12,
    parameter int LINE_W  = 256,
    parameter int BEAT_W  = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loadw_vld,
    input  logic [SRAM_AW-1:0]   loadw_addr,
    input  logic [LINE_W-1:0]    loadw_data,
    output logic                 loadw_rdy,
    input  logic                 loadi_vld,
    input  logic [SRAM_AW-1:0]   loadi_addr,
    input  logic [LINE_W-1:0]    loadi_data,
    output logic                 loadi_rdy,
    input  logic                 lock,
    input  logic                 clr_cnt,
    output logic                 wsram_we,
    output logic [SRAM_AW+1:0]   wsram_addr,
    output logic [BEAT_W-1:0]    wsram_wdata,
    output logic                 isram_we,
    output logic [SRAM_AW+1:0]   isram_addr,
    output logic [BEAT_W-1:0]    isram_wdata,
    output logic                 idle,
    output logic [CNT_W-1:0]     wline_cnt,
    output logic [CNT_W-1:0]     iline_cnt
);

    localparam logic [BEAT_IDX_W-1:0] c_LAST_BEAT = BEAT_IDX_W'(BEATS_PER_LINE - 1);

    ld_state_t               r_state, w_state_nxt;
    logic [BEAT_IDX_W-1:0]   r_beat, w_beat_nxt;
    logic                    r_tgt, w_tgt_nxt;
    logic                    r_last_grant, w_last_nxt;
    logic [LINE_W-1:0]       r_line_buf, w_buf_nxt, w_sel_data;
    logic [SRAM_AW-1:0]      r_line_addr, w_addr_nxt, w_sel_addr;
    logic [1:0]              w_grant;
    logic                    w_win, w_accept, w_active_nxt;
    logic [BEAT_W-1:0]       w_word_nxt;
    logic [SRAM_AW+1:0]      w_waddr_nxt;
    logic                    r_wsram_we, r_isram_we;
    logic [SRAM_AW+1:0]      r_wsram_addr, r_isram_addr;
    logic [BEAT_W-1:0]       r_wsram_wdata, r_isram_wdata;
    logic [CNT_W-1:0]        r_wline_cnt, r_iline_cnt;

    // Accept window: idle or last beat of a line, not locked, not in reset
    assign w_win = !rst && !lock &&
                   ((r_state == LD_IDLE) ||
                    ((r_state == LD_WRITE) && (r_beat == c_LAST_BEAT)));

    cnn_rr_arb2 u_arb (
        .req   ({loadi_vld, loadw_vld}),
        .en    (w_win),
        .last  (r_last_grant),
        .grant (w_grant)
    );

    assign loadw_rdy  = w_grant[TGT_W];
    assign loadi_rdy  = w_grant[TGT_I];
    assign w_accept   = |w_grant;
    assign w_sel_data = w_grant[TGT_I] ? loadi_data : loadw_data;
    assign w_sel_addr = w_grant[TGT_I] ? loadi_addr : loadw_addr;
    assign w_buf_nxt  = w_accept ? w_sel_data : r_line_buf;
    assign w_addr_nxt = w_accept ? w_sel_addr : r_line_addr;

    // Next-state logic: start a line on accept, step beats, chain or go idle
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_tgt_nxt   = r_tgt;
        w_last_nxt  = r_last_grant;
        case (r_state)
            LD_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = LD_WRITE;
                    w_beat_nxt  = '0;
                    w_tgt_nxt   = w_grant[TGT_I];
                    w_last_nxt  = w_grant[TGT_I];
                end
            end
            LD_WRITE: begin
                if (r_beat == c_LAST_BEAT) begin
                    if (w_accept) begin
                        w_beat_nxt = '0;
                        w_tgt_nxt  = w_grant[TGT_I];
                        w_last_nxt = w_grant[TGT_I];
                    end else begin
                        w_state_nxt = LD_IDLE;
                    end
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    // Control and line registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LD_IDLE;
            r_beat       <= '0;
            r_tgt        <= TGT_W;
            r_last_grant <= TGT_I;
            r_line_buf   <= '0;
            r_line_addr  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_tgt        <= w_tgt_nxt;
            r_last_grant <= w_last_nxt;
            r_line_buf   <= w_buf_nxt;
            r_line_addr  <= w_addr_nxt;
        end
    end

    // The beat presented next cycle, computed from next-state values so the
    // SRAM ports are pure registers with no path from the load inputs
    assign w_active_nxt = (w_state_nxt == LD_WRITE);
    assign w_word_nxt   = w_buf_nxt[int'(w_beat_nxt) * BEAT_W +: BEAT_W];
    assign w_waddr_nxt  = {w_addr_nxt, w_beat_nxt};

    // SRAM port registers; an idle port keeps its last address and data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wsram_we    <= 1'b0;
            r_wsram_addr  <= '0;
            r_wsram_wdata <= '0;
            r_isram_we    <= 1'b0;
            r_isram_addr  <= '0;
            r_isram_wdata <= '0;
        end else begin
            r_wsram_we <= w_active_nxt && (w_tgt_nxt == TGT_W);
            r_isram_we <= w_active_nxt && (w_tgt_nxt == TGT_I);
            if (w_active_nxt && (w_tgt_nxt == TGT_W)) begin
                r_wsram_addr  <= w_waddr_nxt;
                r_wsram_wdata <= w_word_nxt;
            end
            if (w_active_nxt && (w_tgt_nxt == TGT_I)) begin
                r_isram_addr  <= w_waddr_nxt;
                r_isram_wdata <= w_word_nxt;
            end
        end
    end

    // Saturating line counters; a clear on an accept edge leaves the winner at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wline_cnt <= '0;
            r_iline_cnt <= '0;
        end else if (clr_cnt) begin
            r_wline_cnt <= w_grant[TGT_W] ? CNT_W'(1) : '0;
            r_iline_cnt <= w_grant[TGT_I] ? CNT_W'(1) : '0;
        end else begin
            if (w_grant[TGT_W] && (r_wline_cnt != '1)) begin
                r_wline_cnt <= r_wline_cnt + 1'b1;
            end
            if (w_grant[TGT_I] && (r_iline_cnt != '1)) begin
                r_iline_cnt <= r_iline_cnt + 1'b1;
            end
        end
    end

    assign wsram_we    = r_wsram_we;
    assign wsram_addr  = r_wsram_addr;
    assign wsram_wdata = r_wsram_wdata;
    assign isram_we    = r_isram_we;
    assign isram_addr  = r_isram_addr;
    assign isram_wdata = r_isram_wdata;
    assign idle        = (r_state == LD_IDLE);
    assign wline_cnt   = r_wline_cnt;
    assign iline_cnt   = r_iline_cnt;

endmodule : cnn_load_ctrl
`default_nettype wire
